reg_file: RTL and testbench

Architectural register file and LL bit for the back end: the write-side consumer of the MEM/WB pipeline register's outputs. It holds 32 x 32-bit general registers (r0 hardwired to zero) and the LL bit. It serves two combinational read ports to the decode stage, with a write-through bypass so that a writeback and a read of the same register in one cycle resolve correctly.

---
 rtl/reg_file_pkg.sv | 7 +
 rtl/llbit_reg.sv | 20 ++
 rtl/reg_file.sv | 46 ++++
 tb/tb_reg_file.sv | 110 +++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared widths and constants for the register file
package reg_file_pkg;
  localparam int REG_WIDTH = 32;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int REG_NUM = 32;
  localparam logic [REG_WIDTH-1:0] ZERO_WORD = '0;
endpackage

// File: rtl/llbit_reg.sv
// llbit_reg: LL bit with rst/flush/write priority; REGFILE_BYPASS_EN adds same-cycle write-through on llbit_out
module llbit_reg (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic write_en,
  input  logic write_data,
  output logic llbit_out
);
  logic llbit;
  always_ff @(posedge clk) begin
    if (rst || flush) llbit <= 1'b0;
    else if (write_en) llbit <= write_data;
  end
`ifdef REGFILE_BYPASS_EN
  always_comb llbit_out = (rst || flush) ? 1'b0 : write_en ? write_data : llbit;
`else
  always_comb llbit_out = (rst || flush) ? 1'b0 : llbit;
`endif
endmodule

// File: rtl/reg_file.sv
// reg_file: 32x32 register file (r0 = 0), two combinational read ports, LL bit; REGFILE_BYPASS_EN enables write-through bypass
module reg_file
  import reg_file_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wb_reg_write_en,
  input  logic [REG_ADDR_WIDTH-1:0] wb_reg_write_addr,
  input  logic [REG_WIDTH-1:0]      wb_reg_write_data,
  input  logic                      wb_LLbit_write_en,
  input  logic                      wb_LLbit_write_data,
  input  logic                      flush,
  input  logic                      reg_read_en1,
  input  logic [REG_ADDR_WIDTH-1:0] reg_read_addr1,
  input  logic                      reg_read_en2,
  input  logic [REG_ADDR_WIDTH-1:0] reg_read_addr2,
  output logic [REG_WIDTH-1:0]      reg_read_data1,
  output logic [REG_WIDTH-1:0]      reg_read_data2,
  output logic                      LLbit_out
);
  logic [REG_WIDTH-1:0] regs [REG_NUM];
  always_ff @(posedge clk) begin
    if (rst) regs <= '{default: ZERO_WORD};
    else if (wb_reg_write_en && wb_reg_write_addr != '0) regs[wb_reg_write_addr] <= wb_reg_write_data;
  end
  function automatic logic [REG_WIDTH-1:0] rd(input logic en, input logic [REG_ADDR_WIDTH-1:0] addr);
`ifdef REGFILE_BYPASS_EN
    return (rst || !en || addr == '0) ? ZERO_WORD :
           (wb_reg_write_en && addr == wb_reg_write_addr) ? wb_reg_write_data : regs[addr];
`else
    return (rst || !en || addr == '0) ? ZERO_WORD : regs[addr];
`endif
  endfunction
  always_comb begin
    reg_read_data1 = rd(reg_read_en1, reg_read_addr1);
    reg_read_data2 = rd(reg_read_en2, reg_read_addr2);
  end
  llbit_reg u_llbit (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .write_en   (wb_LLbit_write_en),
    .write_data (wb_LLbit_write_data),
    .llbit_out  (LLbit_out)
  );
endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: randomized + directed scoreboard bench for reg_file against an array reference model
module tb_reg_file;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic we = 1'b0, lwe = 1'b0, lwd = 1'b0, fl = 1'b0, e1 = 1'b0, e2 = 1'b0;
  logic [4:0] wa = '0, a1 = '0, a2 = '0;
  logic [31:0] wd = '0;
  logic [31:0] d1, d2;
  logic ll_out;
  typedef struct {logic [31:0] d1; logic [31:0] d2; logic ll; string tag;} exp_t;
  exp_t q[$];
  logic [31:0] m [32];
  logic ll_m = 1'b0;
  int checks = 0, failures = 0;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  always #5 clk = ~clk;

  reg_file dut (
    .clk(clk), .rst(rst),
    .wb_reg_write_en(we), .wb_reg_write_addr(wa), .wb_reg_write_data(wd),
    .wb_LLbit_write_en(lwe), .wb_LLbit_write_data(lwd), .flush(fl),
    .reg_read_en1(e1), .reg_read_addr1(a1), .reg_read_en2(e2), .reg_read_addr2(a2),
    .reg_read_data1(d1), .reg_read_data2(d2), .LLbit_out(ll_out)
  );

  function automatic logic [31:0] exp_rd(input logic en, input logic [4:0] a);
    if (rst || !en || a == 0) return 32'h0;
    if (BYP && we && a == wa) return wd;
    return m[a];
  endfunction

  task automatic step(input logic r, input logic w, input logic [4:0] waddr, input logic [31:0] wdata,
                      input logic lw, input logic lv, input logic f,
                      input logic en1, input logic [4:0] ad1, input logic en2, input logic [4:0] ad2,
                      input string tag);
    exp_t e;
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) m[i] = 32'h0;
      ll_m = 1'b0;
    end else begin
      if (we && wa != 0) m[wa] = wd;
      if (fl) ll_m = 1'b0;
      else if (lwe) ll_m = lwd;
    end
    #2;
    rst = r; we = w; wa = waddr; wd = wdata; lwe = lw; lwd = lv; fl = f;
    e1 = en1; a1 = ad1; e2 = en2; a2 = ad2;
    e.d1 = exp_rd(e1, a1);
    e.d2 = exp_rd(e2, a2);
    e.ll = (rst || fl) ? 1'b0 : (BYP && lwe) ? lwd : ll_m;
    e.tag = tag;
    q.push_back(e);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        checks += 3;
        if (d1 !== e.d1) begin failures++; $display("FAIL %s rd1 got=%h exp=%h", e.tag, d1, e.d1); end
        if (d2 !== e.d2) begin failures++; $display("FAIL %s rd2 got=%h exp=%h", e.tag, d2, e.d2); end
        if (ll_out !== e.ll) begin failures++; $display("FAIL %s llbit got=%b exp=%b", e.tag, ll_out, e.ll); end
      end
    end
  end

  initial begin
    for (int i = 0; i < 32; i++) m[i] = 32'h0;
    step(1, 1, 5'd9, 32'h11111111, 1, 1, 0, 1, 5'd9, 1, 5'd9, "reset_hold");
    step(1, 0, 5'd0, 32'h0, 0, 0, 0, 1, 5'd1, 1, 5'd2, "reset_hold");
    for (int i = 1; i < 32; i++)
      step(0, 0, 5'd0, 32'h0, 0, 0, 0, 1, 5'(i), 1, 5'(32 - i), "reset_read");
    step(0, 1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 0, 5'd0, 0, 5'd0, "write_r5");
    step(0, 0, 5'd0, 32'h0, 0, 0, 0, 1, 5'd5, 0, 5'd5, "read_r5");
    step(0, 1, 5'd0, 32'h12345678, 0, 0, 0, 1, 5'd0, 1, 5'd0, "r0_write");
    step(0, 0, 5'd0, 32'h0, 0, 0, 0, 1, 5'd0, 1, 5'd0, "r0_after");
    step(0, 1, 5'd7, 32'h01020304, 0, 0, 0, 0, 5'd0, 0, 5'd0, "r7_old");
    step(0, 1, 5'd7, 32'hA5A5A5A5, 0, 0, 0, 1, 5'd7, 1, 5'd7, "bypass_r7");
    step(0, 0, 5'd0, 32'h0, 0, 0, 0, 1, 5'd7, 1, 5'd7, "r7_after");
    step(0, 0, 5'd0, 32'h0, 1, 1, 0, 0, 5'd0, 0, 5'd0, "ll_set");
    step(0, 0, 5'd0, 32'h0, 0, 0, 0, 0, 5'd0, 0, 5'd0, "ll_held");
    step(0, 0, 5'd0, 32'h0, 1, 1, 1, 0, 5'd0, 0, 5'd0, "ll_flush_wr");
    step(0, 0, 5'd0, 32'h0, 0, 0, 0, 0, 5'd0, 0, 5'd0, "ll_after_flush");
    step(1, 1, 5'd3, 32'h000000FF, 1, 1, 0, 1, 5'd3, 1, 5'd5, "rst_mid_write");
    step(0, 0, 5'd0, 32'h0, 0, 0, 0, 1, 5'd3, 1, 5'd5, "after_rst");
    for (int n = 0; n < 3000; n++) begin
      logic [4:0] ra, rb, rw;
      rw = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      ra = ($urandom_range(0, 2) == 0) ? rw : 5'($urandom_range(0, 7));
      rb = ($urandom_range(0, 2) == 0) ? rw : 5'($urandom);
      step($urandom_range(0, 60) == 0, 1'($urandom), rw, $urandom, 1'($urandom), 1'($urandom),
           $urandom_range(0, 7) == 0, $urandom_range(0, 7) != 0, ra, $urandom_range(0, 7) != 0, rb, "random");
    end
    for (int t = 0; t < 10 && q.size() != 0; t++) @(posedge clk);
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d exp=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
